// File: rtl/wfq_div_arbiter.sv
// Round-robin arbiter sharing one fixed-latency pipelined divider among NREQ requesters.
// Optional divide-by-zero detection enabled by defining WFQ_DIV_ZERO_DETECT_EN.
module wfq_div_arbiter #(
    parameter int unsigned N       = 16,
    parameter int unsigned NREQ    = 4,
    parameter int unsigned IDW     = 2,
    parameter int unsigned DIV_LAT = 18
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] req_dividend,
    input  logic [NREQ*N-1:0] req_divisor,
    output logic [NREQ-1:0]   gnt,
    output logic [N-1:0]      div_dividend,
    output logic [N-1:0]      div_divisor,
    input  logic [N-1:0]      div_quotient,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [N-1:0]      rsp_quotient,
    output logic              busy,
    output logic [NREQ-1:0]   rsp_err
);

    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [N-1:0]       dvd_q, dvd_d;
    logic [N-1:0]       dvs_q, dvs_d;
    logic               iss_v_q, iss_v_d;
    logic [IDW-1:0]     iss_id_q, iss_id_d;
    logic [DIV_LAT-1:0] tag_v_q, tag_v_d;
    logic [IDW-1:0]     tag_id_q [DIV_LAT];
    logic [IDW-1:0]     tag_id_d [DIV_LAT];
    logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [N-1:0]       rsp_quot_q, rsp_quot_d;
    logic [NREQ-1:0]    req_eff;
    logic               win_v;
    logic [IDW-1:0]     win_id;
`ifdef WFQ_DIV_ZERO_DETECT_EN
    logic               iss_z_q, iss_z_d;
    logic [DIV_LAT-1:0] tag_z_q, tag_z_d;
    logic [NREQ-1:0]    rsp_err_q, rsp_err_d;
`endif

    // A requester still holding req during its grant cycle is masked out.
    always_comb begin
        req_eff = req & ~gnt_q;
        win_v   = 1'b0;
        win_id  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!win_v && req_eff[(32'(ptr_q) + k) % NREQ]) begin
                win_v  = 1'b1;
                win_id = IDW'((32'(ptr_q) + k) % NREQ);
            end
        end
    end

    always_comb begin
        ptr_d    = ptr_q;
        gnt_d    = '0;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        iss_v_d  = win_v;
        iss_id_d = win_id;
        if (win_v) begin
            gnt_d = NREQ'(1) << win_id;
            dvd_d = req_dividend[win_id*N +: N];
            dvs_d = req_divisor[win_id*N +: N];
            ptr_d = (win_id == IDW'(NREQ - 1)) ? '0 : win_id + 1'b1;
        end
    end

    // The issue register is the first stage; the tag chain then tracks the divider exactly.
    always_comb begin
        tag_v_d     = {tag_v_q[DIV_LAT-2:0], iss_v_q};
        tag_id_d[0] = iss_id_q;
        for (int unsigned k = 1; k < DIV_LAT; k++) begin
            tag_id_d[k] = tag_id_q[k-1];
        end
        rsp_valid_d = '0;
        rsp_quot_d  = rsp_quot_q;
`ifdef WFQ_DIV_ZERO_DETECT_EN
        iss_z_d   = win_v && (dvs_d == '0);
        tag_z_d   = {tag_z_q[DIV_LAT-2:0], iss_z_q};
        rsp_err_d = '0;
`endif
        if (tag_v_q[DIV_LAT-1]) begin
            rsp_valid_d = NREQ'(1) << tag_id_q[DIV_LAT-1];
            rsp_quot_d  = div_quotient;
`ifdef WFQ_DIV_ZERO_DETECT_EN
            if (tag_z_q[DIV_LAT-1]) begin
                rsp_quot_d = '1;
                rsp_err_d  = rsp_valid_d;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            gnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            iss_v_q     <= 1'b0;
            iss_id_q    <= '0;
            tag_v_q     <= '0;
            rsp_valid_q <= '0;
            rsp_quot_q  <= '0;
`ifdef WFQ_DIV_ZERO_DETECT_EN
            iss_z_q     <= 1'b0;
            tag_z_q     <= '0;
            rsp_err_q   <= '0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            iss_v_q     <= iss_v_d;
            iss_id_q    <= iss_id_d;
            tag_v_q     <= tag_v_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_quot_q  <= rsp_quot_d;
`ifdef WFQ_DIV_ZERO_DETECT_EN
            iss_z_q     <= iss_z_d;
            tag_z_q     <= tag_z_d;
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    // Ids are only meaningful alongside their valid bit, so they need no reset.
    always_ff @(posedge clk) begin
        tag_id_q <= tag_id_d;
    end

    assign gnt          = gnt_q;
    assign div_dividend = dvd_q;
    assign div_divisor  = dvs_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_quotient = rsp_quot_q;
    assign busy         = iss_v_q | (|tag_v_q);
`ifdef WFQ_DIV_ZERO_DETECT_EN
    assign rsp_err      = rsp_err_q;
`else
    assign rsp_err      = '0;
`endif

endmodule

// File: tb/tb_wfq_div_arbiter.sv
// Directed bench for wfq_div_arbiter with a stub pipelined divider of DIV_LAT stages.
module tb_wfq_div_arbiter;

    localparam int N       = 16;
    localparam int NREQ    = 4;
    localparam int DIV_LAT = 18;

    logic                clk;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [NREQ*N-1:0]   req_dividend;
    logic [NREQ*N-1:0]   req_divisor;
    logic [NREQ-1:0]     gnt;
    logic [N-1:0]        div_dividend;
    logic [N-1:0]        div_divisor;
    logic [N-1:0]        div_quotient;
    logic [NREQ-1:0]     rsp_valid;
    logic [N-1:0]        rsp_quotient;
    logic                busy;
    logic [NREQ-1:0]     rsp_err;

    int checks = 0;
    int errors = 0;

    wfq_div_arbiter #(
        .N       (N),
        .NREQ    (NREQ),
        .IDW     (2),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_dividend (req_dividend),
        .req_divisor  (req_divisor),
        .gnt          (gnt),
        .div_dividend (div_dividend),
        .div_divisor  (div_divisor),
        .div_quotient (div_quotient),
        .rsp_valid    (rsp_valid),
        .rsp_quotient (rsp_quotient),
        .busy         (busy),
        .rsp_err      (rsp_err)
    );

    // Stub divider: DIV_LAT cycles from operand change to quotient; x/0 yields a marker.
    logic [N-1:0] stub_q [DIV_LAT];
    always_ff @(posedge clk) begin
        stub_q[0] <= (div_divisor == '0) ? 16'hDEAD : div_dividend / div_divisor;
        for (int k = 1; k < DIV_LAT; k++) stub_q[k] <= stub_q[k-1];
    end
    assign div_quotient = stub_q[DIV_LAT-1];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int          id;
        logic [15:0] dvd;
        logic [15:0] dvs;
        logic [15:0] exp_q;
        logic        exp_err;
    } vec_t;

    vec_t        vecs [6];
    logic [15:0] all_dvd [4];
    logic [15:0] all_dvs [4];
    logic [15:0] all_q   [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((busy || rsp_valid != '0) && n < 60) begin
            tick();
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    task automatic set_ops(input int id, input logic [15:0] dvd, input logic [15:0] dvs);
        req_dividend[id*N +: N] = dvd;
        req_divisor[id*N +: N]  = dvs;
    endtask

    int          n;
    int          bad;
    int          id;
    logic [15:0] save_dd;
    logic [15:0] save_ds;

    initial begin
        vecs[0] = '{2, 16'h0100, 16'h0010, 16'h0010, 1'b0};
        vecs[1] = '{0, 16'd1000, 16'd10,   16'd100,  1'b0};
        vecs[2] = '{1, 16'd999,  16'd3,    16'd333,  1'b0};
`ifdef WFQ_DIV_ZERO_DETECT_EN
        vecs[3] = '{3, 16'h1234, 16'h0000, 16'hFFFF, 1'b1};
`else
        vecs[3] = '{3, 16'h1234, 16'h0000, 16'hDEAD, 1'b0};
`endif
        vecs[4] = '{2, 16'hFFFF, 16'd1,    16'hFFFF, 1'b0};
        vecs[5] = '{0, 16'd7,    16'd9,    16'd0,    1'b0};
        all_dvd = '{16'd1000, 16'd999, 16'd5000, 16'd65535};
        all_dvs = '{16'd10,   16'd3,   16'd7,    16'd255};
        all_q   = '{16'd100,  16'd333, 16'd714,  16'd257};

        rst = 1'b1;
        req = '0;
        req_dividend = '0;
        req_divisor  = '0;
        tick();
        tick();
        check("reset_gnt", 32'(gnt), 0);
        check("reset_rsp_valid", 32'(rsp_valid), 0);
        check("reset_rsp_err", 32'(rsp_err), 0);
        check("reset_rsp_quotient", 32'(rsp_quotient), 0);
        check("reset_div_dividend", 32'(div_dividend), 0);
        check("reset_div_divisor", 32'(div_divisor), 0);
        check("reset_busy", 32'(busy), 0);
        rst = 1'b0;
        tick();

        // Single requests: grant, operand capture, latency, routing, hold.
        for (int v = 0; v < 6; v++) begin
            id = vecs[v].id;
            set_ops(id, vecs[v].dvd, vecs[v].dvs);
            req[id] = 1'b1;
            tick();
            n = 1;
            check("single_gnt", 32'(gnt), 32'(1 << id));
            check("single_busy", 32'(busy), 1);
            req[id] = 1'b0;
            check("single_div_dividend", 32'(div_dividend), 32'(vecs[v].dvd));
            check("single_div_divisor", 32'(div_divisor), 32'(vecs[v].dvs));
            while (rsp_valid == '0 && n < 40) begin
                tick();
                n++;
            end
            check("single_latency", n, 20);
            check("single_rsp_valid", 32'(rsp_valid), 32'(1 << id));
            check("single_rsp_quotient", 32'(rsp_quotient), 32'(vecs[v].exp_q));
            check("single_rsp_err", 32'(rsp_err), vecs[v].exp_err ? 32'(1 << id) : 0);
            tick();
            check("single_rsp_pulse", 32'(rsp_valid), 0);
            check("single_rsp_hold", 32'(rsp_quotient), 32'(vecs[v].exp_q));
            check("single_busy_done", 32'(busy), 0);
        end

        // All four requesting continuously from pointer 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_ops(i, all_dvd[i], all_dvs[i]);
        req = 4'b1111;
        n = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            n++;
            check("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
        end
        req = '0;
        while (rsp_valid == '0 && n < 40) begin
            tick();
            n++;
        end
        check("rr_latency", n, 20);
        for (int k = 0; k < 8; k++) begin
            check("rr_rsp_valid", 32'(rsp_valid), 32'(1 << (k % 4)));
            check("rr_rsp_quotient", 32'(rsp_quotient), 32'(all_q[k % 4]));
            tick();
        end
        check("rr_rsp_end", 32'(rsp_valid), 0);
        drain("rr_drain");

        // Back-to-back with pointer at 2: req[3] before req[1].
        set_ops(1, 16'd20, 16'd4);
        set_ops(3, 16'd300, 16'd12);
        req[1] = 1'b1;
        tick();
        check("b2b_setup_gnt", 32'(gnt), 32'b0010);
        req[1] = 1'b0;
        drain("b2b_setup_drain");
        req = 4'b1010;
        tick();
        check("b2b_gnt_first", 32'(gnt), 32'b1000);
        req[3] = 1'b0;
        tick();
        check("b2b_gnt_second", 32'(gnt), 32'b0010);
        req[1] = 1'b0;
        n = 2;
        while (rsp_valid == '0 && n < 40) begin
            tick();
            n++;
        end
        check("b2b_latency", n, 20);
        check("b2b_rsp_first", 32'(rsp_valid), 32'b1000);
        check("b2b_quot_first", 32'(rsp_quotient), 32'd25);
        tick();
        check("b2b_rsp_second", 32'(rsp_valid), 32'b0010);
        check("b2b_quot_second", 32'(rsp_quotient), 32'd5);
        drain("b2b_drain");

        // Reset 5 cycles after a grant drops the in-flight division.
        set_ops(1, 16'd100, 16'd4);
        req[1] = 1'b1;
        tick();
        check("rst_pre_gnt", 32'(gnt), 32'b0010);
        req[1] = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 0);
        check("rst_gnt", 32'(gnt), 0);
        check("rst_div_dividend", 32'(div_dividend), 0);
        check("rst_rsp_quotient", 32'(rsp_quotient), 0);
        bad = 0;
        repeat (30) begin
            tick();
            if (rsp_valid != '0 || busy) bad++;
        end
        check("rst_no_rsp", bad, 0);
        set_ops(0, 16'd8, 16'd2);
        set_ops(3, 16'd9, 16'd3);
        req = 4'b1001;
        tick();
        check("rst_ptr_zero", 32'(gnt), 32'b0001);
        req[0] = 1'b0;
        tick();
        check("rst_ptr_next", 32'(gnt), 32'b1000);
        req = '0;
        drain("rst_drain");

        // Idle: nothing moves for 50 cycles.
        save_dd = div_dividend;
        save_ds = div_divisor;
        bad = 0;
        repeat (50) begin
            tick();
            if (gnt != '0 || rsp_valid != '0 || busy || div_dividend != save_dd ||
                div_divisor != save_ds) bad++;
        end
        check("idle_quiet", bad, 0);
        check("idle_dividend_held", 32'(div_dividend), 32'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
